// File: rtl/cpu_clock_ctrl.sv
// Run/step/halt controller for the 4-bit CPU: turns prescaled clk_cpu edges into
// single-cycle cpu_en pulses, with debounced step/mode buttons and halt freeze.
module cpu_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter bit START_RUN       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_cpu,
  input  logic       btn_step,
  input  logic       btn_mode,
  input  logic       cpu_halt,
  output logic       cpu_en,
  output logic       run_mode,
  output logic       halted,
  output logic [7:0] step_cnt
);

  typedef enum logic [1:0] {RUN, STEP_IDLE, STEP_WAIT, HALT} state_t;

  localparam state_t           RESET_STATE = START_RUN ? RUN : STEP_IDLE;
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t state, next_state;

  logic [1:0]       btn_raw, sync1, sync2, stable, stable_q, presses;
  logic [CNT_W-1:0] db_cnt [2];
  logic             clk_cpu_q, tick, step_p, mode_p, issue;

  assign btn_raw = {btn_mode, btn_step};

  // Bit 0 is the step button, bit 1 the mode button; both share one debouncer shape.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_q <= stable;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign presses = stable & ~stable_q;
  assign step_p  = presses[0];
  assign mode_p  = presses[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) clk_cpu_q <= 1'b0;
    else       clk_cpu_q <= clk_cpu;
  end

  assign tick = clk_cpu & ~clk_cpu_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RESET_STATE;
      cpu_en   <= 1'b0;
      step_cnt <= '0;
    end else begin
      state  <= next_state;
      cpu_en <= issue;
      if (cpu_en) step_cnt <= step_cnt + 8'd1;
    end
  end

  // Halt beats everything in RUN; mode beats step in the step states.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    case (state)
      RUN: begin
        if (cpu_halt) begin
          next_state = HALT;
        end else begin
          issue = tick;
          if (mode_p) next_state = STEP_IDLE;
        end
      end
      STEP_IDLE: begin
        if (mode_p)      next_state = RUN;
        else if (step_p) next_state = STEP_WAIT;
      end
      STEP_WAIT: begin
        if (mode_p) begin
          next_state = RUN;
        end else if (tick) begin
          if (cpu_halt) begin
            next_state = HALT;
          end else begin
            issue      = 1'b1;
            next_state = STEP_IDLE;
          end
        end
      end
      HALT: begin
        if (mode_p) next_state = STEP_IDLE;
      end
      default: next_state = RESET_STATE;
    endcase
  end

  assign run_mode = (state == RUN);
  assign halted   = (state == HALT);

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Self-checking bench for cpu_clock_ctrl: randomized button/halt operations scored
// against a per-clk_cpu-period model of how many pulses each operation should yield.
module tb_cpu_clock_ctrl;

  localparam int D      = 4;
  localparam int M_RUN  = 0;
  localparam int M_IDLE = 1;
  localparam int M_HALT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_cpu = 1'b0;
  logic       btn_step = 1'b0;
  logic       btn_mode = 1'b0;
  logic       cpu_halt = 1'b0;
  logic       cpu_en, run_mode, halted;
  logic [7:0] step_cnt;

  int tests = 0;
  int fails = 0;
  int obs = 0;
  int exp_pulses = 0;
  int mstate = M_RUN;
  logic c1 = 1'b0, c2 = 1'b0, en_prev = 1'b0;

  cpu_clock_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .START_RUN(1'b1)) dut (
    .clk(clk), .reset(reset), .clk_cpu(clk_cpu), .btn_step(btn_step),
    .btn_mode(btn_mode), .cpu_halt(cpu_halt), .cpu_en(cpu_en),
    .run_mode(run_mode), .halted(halted), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  // clk_cpu: 5 cycles high, 5 low, changing just after each rising clk edge.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      clk_cpu = (ph < 5);
      ph = (ph + 1) % 10;
    end
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Every pulse must follow a clk_cpu rise seen one cycle earlier and never repeat back-to-back.
  always @(negedge clk) begin
    if (reset) begin
      obs     <= 0;
      en_prev <= 1'b0;
    end else begin
      if (cpu_en) begin
        checkOutput("en_after_tick", int'(c1 & ~c2), 1);
        checkOutput("en_spacing", int'(en_prev), 0);
        obs <= obs + 1;
      end
      en_prev <= cpu_en;
    end
    c2 <= c1;
    c1 <= clk_cpu;
  end

  task automatic tickc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int runs(input int s);
    return (s == M_RUN) ? 1 : 0;
  endfunction

  task automatic checkState(input string tag);
    checkOutput({tag, "_cnt"}, int'(step_cnt), exp_pulses % 256);
    checkOutput({tag, "_pulses"}, obs, exp_pulses);
    checkOutput({tag, "_run_mode"}, int'(run_mode), runs(mstate));
    checkOutput({tag, "_halted"}, int'(halted), (mstate == M_HALT) ? 1 : 0);
  endtask

  // All operations start and end 5 cycles after a clk_cpu rise and span whole periods.
  task automatic opWait(input int n, input bit h);
    cpu_halt = h;
    if (h && mstate == M_RUN) mstate = M_HALT;
    else exp_pulses += n * runs(mstate);
    tickc(10 * n);
    cpu_halt = 1'b0;
    checkState("wait");
  endtask

  task automatic opMode(input bit both);
    int old_s;
    old_s  = mstate;
    mstate = (old_s == M_IDLE) ? M_RUN : M_IDLE;
    exp_pulses += runs(old_s) + 2 * runs(mstate);
    tickc(3);
    btn_mode = 1'b1;
    btn_step = both;
    tickc(12);
    btn_mode = 1'b0;
    btn_step = 1'b0;
    tickc(15);
    checkState(both ? "both" : "mode");
  endtask

  task automatic opStep(input bit h, input bit bounce);
    cpu_halt = h;
    if (mstate == M_RUN) begin
      if (h) mstate = M_HALT;
      else   exp_pulses += 3;
    end else if (mstate == M_IDLE) begin
      if (h) mstate = M_HALT;
      else   exp_pulses += 1;
    end
    if (bounce) begin
      for (int i = 0; i < 3; i++) begin
        btn_step = 1'b1;
        tickc(1);
        btn_step = 1'b0;
        tickc(1);
      end
      btn_step = 1'b1;
      tickc(12);
      btn_step = 1'b0;
      tickc(12);
    end else begin
      tickc(3);
      btn_step = 1'b1;
      tickc(12);
      btn_step = 1'b0;
      tickc(15);
    end
    cpu_halt = 1'b0;
    checkState("step");
  endtask

  task automatic opBounce();
    int t, hi, lo;
    t = 0;
    exp_pulses += 3 * runs(mstate);
    while (t < 18) begin
      hi = $urandom_range(1, D - 1);
      lo = $urandom_range(1, 3);
      btn_step = 1'b1;
      tickc(hi);
      btn_step = 1'b0;
      tickc(lo);
      t += hi + lo;
    end
    tickc(30 - t);
    checkState("bounce");
  endtask

  task automatic opReset();
    if (mstate == M_IDLE) begin
      tickc(3);
      btn_step = 1'b1;
      tickc(9);
      reset = 1'b1;
      #2;
      checkOutput("rst_wait_en", int'(cpu_en), 0);
      checkOutput("rst_wait_cnt", int'(step_cnt), 0);
      checkOutput("rst_wait_run_mode", int'(run_mode), 1);
      tickc(1);
      reset = 1'b0;
      tickc(2);
      btn_step = 1'b0;
      tickc(15);
    end else begin
      tickc(6);
      reset = 1'b1;
      #2;
      checkOutput("rst_pulse_en", int'(cpu_en), 0);
      checkOutput("rst_pulse_cnt", int'(step_cnt), 0);
      checkOutput("rst_pulse_halted", int'(halted), 0);
      tickc(4);
      reset = 1'b0;
      tickc(20);
    end
    mstate     = M_RUN;
    exp_pulses = 2;
    checkState("reset");
  endtask

  task automatic applyStimulus(input int op);
    case (op)
      0: opWait($urandom_range(1, 4), ($urandom_range(0, 3) == 0));
      1: opMode(1'b0);
      2: opStep(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
      3: opBounce();
      4: opMode(1'b1);
      default: opReset();
    endcase
  endtask

  initial begin
    tickc(2);
    checkOutput("reset_en", int'(cpu_en), 0);
    checkOutput("reset_cnt", int'(step_cnt), 0);
    checkOutput("reset_halted", int'(halted), 0);
    checkOutput("reset_run_mode", int'(run_mode), 1);

    // Release reset while clk_cpu is low so the first rise is a genuine tick.
    @(posedge clk_cpu);
    tickc(5);
    tickc(2);
    reset = 1'b0;
    tickc(28);
    exp_pulses = 3;
    checkState("first");
    opWait(7, 1'b0);
    checkOutput("run_100_cnt", int'(step_cnt), 10);

    opMode(1'b0);
    opStep(1'b0, 1'b0);
    opWait(5, 1'b0);
    opBounce();
    opStep(1'b0, 1'b1);
    opMode(1'b0);
    opWait(1, 1'b1);
    opWait(10, 1'b0);
    opMode(1'b0);
    opMode(1'b1);
    opWait(250, 1'b0);
    opReset();
    opMode(1'b0);
    opReset();

    for (int i = 0; i < 40; i++) applyStimulus($urandom_range(0, 5));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_clock_ctrl.md
# cpu_clock_ctrl

Run/step/halt controller for the 4-bit CPU. It sits directly downstream of the clock prescaler and consumes its `clk_cpu` square wave. In RUN it turns each `clk_cpu` rising edge into a one-cycle clock-enable pulse (`cpu_en`) in the `clk` domain. In STEP it issues exactly one pulse per debounced push-button press. It freezes the CPU when the core reports a halt.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required before a button level is accepted (20 ms at 50 MHz).
- `CNT_W`, default 20: debounce counter width; must hold `DEBOUNCE_CYCLES`.
- `START_RUN`, default 1: state after reset. 1 = RUN, 0 = STEP_IDLE.
- `clk` in 1: system clock. Same clock that drives the prescaler.
- `reset` in 1: asynchronous, active-high.
- `clk_cpu` in 1: prescaled CPU clock level. Registered in the `clk` domain, so it needs no synchronizer.
- `btn_step` in 1: raw step push-button, active-high, asynchronous.
- `btn_mode` in 1: raw run/step toggle push-button, active-high, asynchronous.
- `cpu_halt` in 1: halt flag from the CPU core, synchronous to `clk`.
- `cpu_en` out 1: one-`clk`-cycle enable pulse; the CPU advances one instruction per pulse.
- `run_mode` out 1: 1 in RUN, 0 otherwise.
- `halted` out 1: 1 in HALT.
- `step_cnt` out 8: count of issued `cpu_en` pulses; wraps from 255 to 0.

## Operation
- **Input synchronizers:** `btn_step` and `btn_mode` each pass through a 2-flop synchronizer.
- **Debounce, per button:**
  - The counter increments while the synchronized level differs from the stable level.
  - It clears to 0 whenever the two are equal.
  - When the count reaches `DEBOUNCE_CYCLES - 1`, the stable level takes the synchronized level and the counter clears.
- **Press pulses:** a 0→1 transition of a stable level produces a one-cycle press pulse, `step_p` or `mode_p`.
- **Tick:** `tick = clk_cpu & ~clk_cpu_q`, where `clk_cpu_q` is `clk_cpu` delayed by one cycle. A constant-high `clk_cpu` produces no tick.
- **FSM states:** RUN, STEP_IDLE, STEP_WAIT, HALT.
  - RUN:
    - `cpu_halt` → HALT, no pulse.
    - Otherwise, on `tick` issue a pulse.
    - `mode_p` → STEP_IDLE. A tick in the same cycle is still pulsed.
  - STEP_IDLE:
    - `mode_p` → RUN.
    - Otherwise `step_p` → STEP_WAIT.
    - If both arrive in the same cycle, mode wins and the step press is dropped.
  - STEP_WAIT:
    - `mode_p` → RUN, with no extra pulse.
    - Otherwise, on `tick`: if `cpu_halt` → HALT with no pulse; else issue a pulse and go to STEP_IDLE.
    - Further `step_p` presses while waiting are ignored; there is no queueing.
  - HALT:
    - `cpu_en` held 0.
    - `mode_p` → STEP_IDLE.
    - `step_p` and `tick` are ignored.
- **Issued pulse:** `cpu_en` goes high for exactly one cycle and `step_cnt` increments by 1, modulo 256.
- **Pulse spacing:** at most one pulse per `clk_cpu` period. `cpu_en` never asserts on two consecutive cycles.
- **Outputs:** `run_mode` and `halted` are decoded from registered state. They change in the same cycle as the state register.

## Timing
- **Reset values:**
  - `cpu_en` = 0, `step_cnt` = 0, `halted` = 0, `run_mode` = `START_RUN`.
  - State = RUN if `START_RUN` = 1, else STEP_IDLE.
  - Debounce counters and stable levels = 0; synchronizers = 0; `clk_cpu_q` = 0.
- **Pulse latency:** `clk_cpu` rises at edge N, so `tick` is high during cycle N. `cpu_en` is high during cycle N+1, and `step_cnt` updates at the end of cycle N+1.
- **Button latency:** the raw button rises before edge M. `step_p` or `mode_p` is high 2 (synchronizer) + `DEBOUNCE_CYCLES` + 1 cycles later, ±1 cycle.
- **Release:** release is debounced identically but produces no pulse.
- **Glitches:** a bounce shorter than `DEBOUNCE_CYCLES` produces no press.
- **Reset mid-operation:** asserting `reset` during a `cpu_en` pulse or in STEP_WAIT clears the output immediately (asynchronously). The pending step is lost.

## Test plan
Simulation settings for all cases: `DEBOUNCE_CYCLES` = 4, `clk_cpu` period 10 cycles (5 high, 5 low).

- **Run after reset:** `START_RUN` = 1, release reset, run 100 cycles.
  - 10 `cpu_en` pulses, each 1 cycle wide, each one cycle after a `clk_cpu` rise.
  - `step_cnt` = 10, `run_mode` = 1.
- **Mode toggle and single step:**
  - Press `btn_mode` clean for 10 cycles → `run_mode` = 0, pulses stop.
  - Press `btn_step` once → exactly 1 pulse at the next `clk_cpu` rise, then none for 50 cycles.
- **Bounce rejection:** in STEP_IDLE, toggle `btn_step` 1-cycle high/low ×6, then hold high 10 cycles.
  - Exactly 1 pulse.
  - A bounce of 3 high cycles then low → 0 pulses.
- **Halt:** in RUN, assert `cpu_halt` before a tick.
  - No pulse on that tick; `halted` = 1; no pulses for 100 cycles.
  - A `btn_mode` press → STEP_IDLE, `halted` = 0.
- **Simultaneous and wrap cases:**
  - `btn_mode` and `btn_step` debounced on the same cycle in STEP_IDLE → RUN, no extra pulse.
  - 256 pulses from `step_cnt` = 0 → `step_cnt` = 0.
- **Reset mid-step:** in STEP_WAIT, assert `reset` for 1 cycle before the tick.
  - No pulse; state = `START_RUN` state.
  - `step_cnt` = 0 and `cpu_en` = 0 immediately on reset assertion.
